// File: rtl/doorlock_ctrl.sv
// PIN-checking door lock controller: compares assembled PIN packets with a stored PIN,
// drives the lock actuator, alarm and status code, and enforces attempt lockout and PIN change.
module doorlock_ctrl #(
  parameter logic [15:0] DEFAULT_PIN   = 16'h4321,
  parameter int          MAX_ATTEMPTS  = 3,
  parameter int          UNLOCK_TICKS  = 5,
  parameter int          LOCKOUT_TICKS = 30,
  parameter int          SETUP_TICKS   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pin_status,
  input  logic [15:0] pin_digits,
  input  logic        setup_req,
  input  logic        tick,
  input  logic        door_open,
  output logic        unlock,
  output logic        alarm,
  output logic        lockout,
  output logic [2:0]  attempts_left,
  output logic        pin_changed,
  output logic [3:0]  disp_code,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_UNLOCKED   = 3'd1,
    S_AJAR       = 3'd2,
    S_LOCKOUT    = 3'd3,
    S_SETUP_AUTH = 3'd4,
    S_SETUP_NEW  = 3'd5
  } state_t;

  localparam logic [2:0]  ATT_MAX = 3'(MAX_ATTEMPTS);
  localparam logic [15:0] T_UNLK  = 16'(UNLOCK_TICKS);
  localparam logic [15:0] T_LOCK  = 16'(LOCKOUT_TICKS);
  localparam logic [15:0] T_SETUP = 16'(SETUP_TICKS);

  state_t      r_state;
  logic [15:0] r_pin;
  logic [15:0] r_timer;
  logic [2:0]  r_attempts;
  logic        r_status_d;
  logic        r_unlock;
  logic        r_alarm;
  logic        r_lockout;
  logic        r_pin_changed;
  logic [3:0]  r_disp;

  state_t      w_state_n;
  logic [15:0] w_timer_n;
  logic [15:0] w_timer_dec;
  logic [2:0]  w_att_n;
  logic        w_ev;
  logic        w_match;
  logic        w_expire;
  logic        w_digits_ok;
  logic        w_store;

  function automatic logic [3:0] disp_of(input state_t s);
    case (s)
      S_UNLOCKED:   disp_of = 4'h0;
      S_AJAR:       disp_of = 4'hD;
      S_LOCKOUT:    disp_of = 4'hF;
      S_SETUP_AUTH: disp_of = 4'hC;
      S_SETUP_NEW:  disp_of = 4'hE;
      default:      disp_of = 4'hA;
    endcase
  endfunction

  always_comb begin
    // Rising edge of the status flag: one event per PIN however long it is held.
    w_ev        = pin_status & ~r_status_d;
    w_match     = (pin_digits == r_pin);
    w_expire    = tick & (r_timer == 16'd1);
    w_digits_ok = (pin_digits[3:0] <= 4'd9) & (pin_digits[7:4] <= 4'd9) &
                  (pin_digits[11:8] <= 4'd9) & (pin_digits[15:12] <= 4'd9);
    w_timer_dec = tick ? (r_timer - 16'd1) : r_timer;
    w_state_n   = r_state;
    w_timer_n   = r_timer;
    w_att_n     = r_attempts;
    w_store     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ev) begin
          if (w_match) begin
            w_state_n = S_UNLOCKED;
            w_timer_n = T_UNLK;
            w_att_n   = ATT_MAX;
          end else if (r_attempts == 3'd1) begin
            w_state_n = S_LOCKOUT;
            w_timer_n = T_LOCK;
            w_att_n   = 3'd0;
          end else begin
            w_att_n   = r_attempts - 3'd1;
            w_timer_n = 16'd0;
          end
        end else if (setup_req) begin
          w_state_n = S_SETUP_AUTH;
          w_timer_n = T_SETUP;
        end
      end
      S_UNLOCKED: begin
        w_timer_n = w_timer_dec;
        if (w_expire) begin
          w_state_n = door_open ? S_AJAR : S_IDLE;
          w_timer_n = 16'd0;
        end
      end
      S_AJAR: begin
        if (!door_open) w_state_n = S_IDLE;
      end
      S_LOCKOUT: begin
        w_timer_n = w_timer_dec;
        if (w_expire) begin
          w_state_n = S_IDLE;
          w_timer_n = 16'd0;
          w_att_n   = ATT_MAX;
        end
      end
      S_SETUP_AUTH: begin
        w_timer_n = w_timer_dec;
        if (w_ev) begin
          if (w_match) begin
            w_state_n = S_SETUP_NEW;
            w_timer_n = T_SETUP;
          end else if (r_attempts == 3'd1) begin
            w_state_n = S_LOCKOUT;
            w_timer_n = T_LOCK;
            w_att_n   = 3'd0;
          end else begin
            w_state_n = S_IDLE;
            w_att_n   = r_attempts - 3'd1;
            w_timer_n = 16'd0;
          end
        end else if (w_expire) begin
          w_state_n = S_IDLE;
          w_timer_n = 16'd0;
        end
      end
      S_SETUP_NEW: begin
        w_timer_n = w_timer_dec;
        if (w_ev) begin
          w_state_n = S_IDLE;
          w_timer_n = 16'd0;
          w_store   = w_digits_ok;
        end else if (w_expire) begin
          w_state_n = S_IDLE;
          w_timer_n = 16'd0;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_timer_n = 16'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_pin         <= DEFAULT_PIN;
      r_timer       <= 16'd0;
      r_attempts    <= ATT_MAX;
      r_status_d    <= 1'b0;
      r_unlock      <= 1'b0;
      r_alarm       <= 1'b0;
      r_lockout     <= 1'b0;
      r_pin_changed <= 1'b0;
      r_disp        <= 4'hA;
    end else begin
      r_state       <= w_state_n;
      r_timer       <= w_timer_n;
      r_attempts    <= w_att_n;
      r_status_d    <= pin_status;
      r_unlock      <= (w_state_n == S_UNLOCKED);
      r_alarm       <= (w_state_n == S_LOCKOUT) || (w_state_n == S_AJAR);
      r_lockout     <= (w_state_n == S_LOCKOUT);
      r_pin_changed <= w_store;
      r_disp        <= disp_of(w_state_n);
      if (w_store) r_pin <= pin_digits;
    end
  end

  assign unlock        = r_unlock;
  assign alarm         = r_alarm;
  assign lockout       = r_lockout;
  assign attempts_left = r_attempts;
  assign pin_changed   = r_pin_changed;
  assign disp_code     = r_disp;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Bench for doorlock_ctrl: directed walk through the lock scenarios, then randomized traffic,
// every cycle compared against a behavioural model of the lock rules.
module tb_doorlock_ctrl;

  localparam int P_ATT   = 3;
  localparam int P_UNLK  = 5;
  localparam int P_LOCK  = 30;
  localparam int P_SETUP = 20;

  // clock / reset block
  logic        clk = 1'b0;
  logic        rst;
  logic        pin_status;
  logic [15:0] pin_digits;
  logic        setup_req;
  logic        tick;
  logic        door_open;
  logic        unlock;
  logic        alarm;
  logic        lockout;
  logic [2:0]  attempts_left;
  logic        pin_changed;
  logic [3:0]  disp_code;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  doorlock_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pin_status    (pin_status),
    .pin_digits    (pin_digits),
    .setup_req     (setup_req),
    .tick          (tick),
    .door_open     (door_open),
    .unlock        (unlock),
    .alarm         (alarm),
    .lockout       (lockout),
    .attempts_left (attempts_left),
    .pin_changed   (pin_changed),
    .disp_code     (disp_code),
    .dbg_state     (dbg_state)
  );

  // scoreboard
  int          n_vec = 0;
  int          n_err = 0;
  string       phase = "reset";
  logic [10:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // behavioural model: lock modes with tick counts since mode entry
  localparam int M_IDLE = 0, M_OPEN = 1, M_AJAR = 2, M_LOCK = 3, M_AUTH = 4, M_NEW = 5;
  int          m_mode;
  int          m_tries;
  int          m_ticks;
  int          m_limit;
  logic [15:0] m_pin;
  bit          m_prev;
  bit          m_pulse;

  task automatic enter(input int mode);
    m_mode  = mode;
    m_ticks = 0;
    case (mode)
      M_OPEN:         m_limit = P_UNLK;
      M_LOCK:         m_limit = P_LOCK;
      M_AUTH, M_NEW:  m_limit = P_SETUP;
      default:        m_limit = 0;
    endcase
  endtask

  task automatic wrong_pin();
    m_tries--;
    if (m_tries == 0) enter(M_LOCK);
    else enter(M_IDLE);
  endtask

  task automatic model_step();
    bit ev, match, expired, ok;
    if (!rst) begin
      m_pin = 16'h4321; m_tries = P_ATT; m_prev = 0; m_pulse = 0;
      enter(M_IDLE);
      return;
    end
    ev      = pin_status && !m_prev;
    m_prev  = pin_status;
    m_pulse = 0;
    match   = (pin_digits == m_pin);
    expired = 0;
    if (tick && m_limit > 0) begin
      m_ticks++;
      expired = (m_ticks == m_limit);
    end
    case (m_mode)
      M_IDLE: begin
        if (ev) begin
          if (match) begin m_tries = P_ATT; enter(M_OPEN); end
          else wrong_pin();
        end else if (setup_req) enter(M_AUTH);
      end
      M_OPEN: if (expired) enter(door_open ? M_AJAR : M_IDLE);
      M_AJAR: if (!door_open) enter(M_IDLE);
      M_LOCK: if (expired) begin m_tries = P_ATT; enter(M_IDLE); end
      M_AUTH: begin
        if (ev) begin
          if (match) enter(M_NEW);
          else wrong_pin();
        end else if (expired) enter(M_IDLE);
      end
      M_NEW: begin
        if (ev) begin
          ok = 1;
          for (int k = 0; k < 4; k++) if (pin_digits[4*k +: 4] > 4'd9) ok = 0;
          if (ok) begin m_pin = pin_digits; m_pulse = 1; end
          enter(M_IDLE);
        end else if (expired) enter(M_IDLE);
      end
      default: enter(M_IDLE);
    endcase
  endtask

  function automatic logic [10:0] model_out();
    logic [3:0] d;
    case (m_mode)
      M_OPEN:  d = 4'h0;
      M_AJAR:  d = 4'hD;
      M_LOCK:  d = 4'hF;
      M_AUTH:  d = 4'hC;
      M_NEW:   d = 4'hE;
      default: d = 4'hA;
    endcase
    return {m_mode == M_OPEN, (m_mode == M_LOCK) || (m_mode == M_AJAR), m_mode == M_LOCK,
            3'(m_tries), m_pulse, d};
  endfunction

  // driver tasks
  task automatic cyc();
    logic [10:0] e;
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(phase, {5'd0, unlock, alarm, lockout, attempts_left, pin_changed, disp_code}, {5'd0, e});
  endtask

  task automatic enter_pin(input logic [15:0] d, input int hold);
    pin_digits = d;
    pin_status = 1'b1;
    repeat (hold) cyc();
    pin_status = 1'b0;
    cyc();
  endtask

  task automatic tick_cycles(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
  endtask

  function automatic logic [15:0] pick_digits();
    logic [15:0] v;
    case ($urandom_range(0, 5))
      0: v = 16'h4321;
      1: v = 16'h1111;
      2: v = m_pin;
      3: for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
      4: v = 16'hE765;
      default: v = 16'h8765;
    endcase
    return v;
  endfunction

  initial begin
    rst = 1'b0; pin_status = 1'b0; pin_digits = 16'h0; setup_req = 1'b0;
    tick = 1'b0; door_open = 1'b0;
    #1;
    do_reset();
    check("rst_disp", {12'd0, disp_code}, 16'h000A);
    check("rst_attempts", {13'd0, attempts_left}, 16'd3);

    phase = "unlock";
    pin_digits = 16'h4321; pin_status = 1'b1;
    cyc();
    check("unlock_first_edge", {15'd0, unlock}, 16'd1);
    cyc();
    pin_status = 1'b0;
    cyc();
    tick_cycles(4);
    check("unlock_before_5th", {15'd0, unlock}, 16'd1);
    tick_cycles(1);
    check("unlock_after_5th", {15'd0, unlock}, 16'd0);

    phase = "lockout";
    repeat (3) enter_pin(16'h1111, 1);
    check("lockout_flag", {15'd0, lockout}, 16'd1);
    check("lockout_disp", {12'd0, disp_code}, 16'h000F);
    enter_pin(16'h4321, 2);
    check("lockout_ignores_pin", {15'd0, unlock}, 16'd0);
    tick_cycles(29);
    check("lockout_before_end", {15'd0, lockout}, 16'd1);
    tick_cycles(1);
    check("lockout_end_attempts", {13'd0, attempts_left}, 16'd3);
    check("lockout_end_alarm", {15'd0, alarm}, 16'd0);

    phase = "ajar";
    enter_pin(16'h4321, 1);
    door_open = 1'b1;
    tick_cycles(5);
    check("ajar_alarm", {15'd0, alarm}, 16'd1);
    repeat (3) cyc();
    door_open = 1'b0;
    cyc();
    check("ajar_closed", {15'd0, alarm}, 16'd0);

    phase = "setup";
    setup_req = 1'b1; cyc(); setup_req = 1'b0;
    enter_pin(16'h4321, 1);
    enter_pin(16'h8765, 1);
    enter_pin(16'h4321, 1);
    check("old_pin_fails", {13'd0, attempts_left}, 16'd2);
    enter_pin(16'h8765, 1);
    check("new_pin_unlocks", {15'd0, unlock}, 16'd1);
    tick_cycles(6);

    phase = "setup_blank";
    do_reset();
    setup_req = 1'b1; cyc(); setup_req = 1'b0;
    enter_pin(16'h4321, 1);
    enter_pin(16'hE765, 1);
    enter_pin(16'h4321, 1);
    check("blank_keeps_pin", {15'd0, unlock}, 16'd1);
    tick_cycles(6);
    setup_req = 1'b1; cyc(); setup_req = 1'b0;
    tick_cycles(20);
    check("setup_timeout_disp", {12'd0, disp_code}, 16'h000A);

    phase = "ev_priority";
    setup_req = 1'b1; pin_digits = 16'h4321; pin_status = 1'b1;
    cyc();
    setup_req = 1'b0; pin_status = 1'b0;
    check("ev_beats_setup", {12'd0, disp_code}, 16'h0000);
    cyc();
    rst = 1'b0; cyc(); rst = 1'b1;
    check("rst_mid_unlock", {15'd0, unlock}, 16'd0);

    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      tick      = ($urandom_range(0, 2) == 0);
      setup_req = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 7) == 0) door_open = ~door_open;
      if (pin_status) begin
        if ($urandom_range(0, 1) == 0) pin_status = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        pin_digits = pick_digits();
        pin_status = 1'b1;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
